// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the main-memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned PHY_LEN = 20;
    localparam int unsigned ICLLEN  = 128;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY_I,
        ARB_BUSY_D,
        ARB_FLUSH
    } arb_state_t;

    typedef enum logic {
        ARB_SRC_I,
        ARB_SRC_D
    } arb_src_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational 2-way winner select; fixed priority (D wins ties) or round-robin on ties.
module arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter bit RR = 1'b0
) (
    input  logic     i_req,
    input  logic     d_req,
    input  arb_src_t last_grant,
    output logic     any_req,
    output arb_src_t winner
);

    // last_grant only matters in round-robin mode
    logic unused_last;
    assign unused_last = ^last_grant;

    always_comb begin
        any_req = i_req | d_req;
        winner  = ARB_SRC_D;
        if (i_req && d_req) begin
            if (RR) begin
                winner = (last_grant == ARB_SRC_I) ? ARB_SRC_D : ARB_SRC_I;
            end else begin
                winner = ARB_SRC_D;
            end
        end else if (i_req) begin
            winner = ARB_SRC_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between icache refill and dcache refill/writeback.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; otherwise dcache always wins ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = PHY_LEN,
    parameter int unsigned LINE_W = ICLLEN,
    parameter int unsigned OFFS_W = $clog2(LINE_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    arb_state_t  state;
    arb_src_t    last_grant;
    arb_src_t    owner;
    arb_src_t    winner;
    logic        any_req;
    logic [ADDR_W-1:0] i_line;
    logic [ADDR_W-1:0] d_line;
    logic        unused_offs;

    assign i_line      = {i_addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
    assign d_line      = {d_addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
    assign unused_offs = ^{i_addr[OFFS_W-1:0], d_addr[OFFS_W-1:0]};

    arb_pick #(
        .RR(RrEn)
    ) u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .any_req    (any_req),
        .winner     (winner)
    );

    // Ready requires the owner still asking; a drop in the ack cycle behaves like a flush
    assign i_ready = !rst && (state == ARB_BUSY_I) && mem_req && mem_ack && i_req;
    assign d_ready = !rst && (state == ARB_BUSY_D) && mem_req && mem_ack && d_req;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            last_grant <= ARB_SRC_I;
            owner      <= ARB_SRC_I;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        mem_req <= 1'b1;
                        owner   <= winner;
                        if (winner == ARB_SRC_D) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_line;
                            mem_wdata <= d_wdata;
                            state     <= ARB_BUSY_D;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= i_line;
                            mem_wdata <= '0;
                            state     <= ARB_BUSY_I;
                        end
                    end
                end
                ARB_BUSY_I: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        last_grant <= ARB_SRC_I;
                        state      <= ARB_IDLE;
                    end else if (!i_req) begin
                        state <= ARB_FLUSH;
                    end
                end
                ARB_BUSY_D: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        last_grant <= ARB_SRC_D;
                        state      <= ARB_IDLE;
                    end else if (!d_req) begin
                        state <= ARB_FLUSH;
                    end
                end
                ARB_FLUSH: begin
                    // Never abort memory: wait out the ack silently
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        last_grant <= owner;
                        state      <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (expectations follow ARB_ROUND_ROBIN_EN).
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_req;
    logic [19:0]  i_addr;
    logic         i_ready;
    logic [127:0] i_rdata;
    logic         d_req;
    logic         d_we;
    logic [19:0]  d_addr;
    logic [127:0] d_wdata;
    logic         d_ready;
    logic [127:0] d_rdata;
    logic         mem_req;
    logic         mem_we;
    logic [19:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ack;
    logic [127:0] mem_rdata;

    int total = 0;
    int bad   = 0;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RrOn = 1'b1;
`else
    localparam bit RrOn = 1'b0;
`endif

    mem_arbiter u_dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    logic [19:0] tie_first;
    logic [19:0] tie_second;

    initial begin
        rst = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
        d_wdata = '0; mem_ack = 0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_d_ready", d_ready, 0);

        // 1: single icache load, ack after 3 cycles
        i_req = 1; i_addr = 20'h0123C;
        tick();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 20'h01230);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_i_ready_early", i_ready, 0);
        tick(); tick();
        chk("t1_mem_req_held", mem_req, 1);
        mem_ack = 1; mem_rdata = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF; #1;
        chk("t1_i_ready", i_ready, 1);
        chk("t1_i_rdata", i_rdata, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
        chk("t1_d_ready", d_ready, 0);
        tick();
        mem_ack = 0; i_req = 0; #1;
        chk("t1_idle_mem_req", mem_req, 0);
        chk("t1_idle_i_ready", i_ready, 0);

        // 2: tie with last_grant=I -> D first in both modes, then I
        i_req = 1; i_addr = 20'h55555; d_req = 1; d_we = 0; d_addr = 20'hABCDF;
        tick();
        chk("t2_first_addr", mem_addr, 20'hABCD0);
        mem_ack = 1; mem_rdata = 128'h1; #1;
        chk("t2_d_ready", d_ready, 1);
        chk("t2_i_ready_lose", i_ready, 0);
        tick();
        mem_ack = 0; d_req = 0; #1;
        chk("t2_gap_mem_req", mem_req, 0);
        tick();
        chk("t2_second_req", mem_req, 1);
        chk("t2_second_addr", mem_addr, 20'h55550);
        mem_ack = 1; mem_rdata = 128'h2; #1;
        chk("t2_i_ready", i_ready, 1);
        chk("t2_d_ready_off", d_ready, 0);
        tick();
        mem_ack = 0; i_req = 0;
        tick();

        // 3: dcache writeback
        d_req = 1; d_we = 1; d_addr = 20'h0004F;
        d_wdata = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF;
        tick();
        chk("t3_mem_we", mem_we, 1);
        chk("t3_mem_wdata", mem_wdata, 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF);
        chk("t3_mem_addr", mem_addr, 20'h00040);
        tick();
        mem_ack = 1; #1;
        chk("t3_d_ready", d_ready, 1);
        chk("t3_i_ready", i_ready, 0);
        tick();
        mem_ack = 0; d_req = 0; d_we = 0;
        tick();

        // 2b: tie with last_grant=D -> I first only in round-robin mode
        tie_first  = RrOn ? 20'h11110 : 20'h22220;
        tie_second = RrOn ? 20'h22220 : 20'h11110;
        i_req = 1; i_addr = 20'h11111; d_req = 1; d_addr = 20'h22222;
        tick();
        chk("t2b_first_addr", mem_addr, tie_first);
        mem_ack = 1; #1;
        chk("t2b_first_i_ready", i_ready, RrOn);
        chk("t2b_first_d_ready", d_ready, !RrOn);
        tick();
        mem_ack = 0;
        if (RrOn) i_req = 0; else d_req = 0;
        tick();
        chk("t2b_second_addr", mem_addr, tie_second);
        mem_ack = 1; #1;
        chk("t2b_second_i_ready", i_ready, !RrOn);
        chk("t2b_second_d_ready", d_ready, RrOn);
        tick();
        mem_ack = 0; i_req = 0; d_req = 0;
        tick();

        // 4: icache drops request after grant; pending dcache fill follows
        i_req = 1; i_addr = 20'h3333F;
        tick();
        chk("t4_grant_addr", mem_addr, 20'h33330);
        i_req = 0; d_req = 1; d_addr = 20'h44440; d_we = 0;
        tick();
        chk("t4_flush_mem_req", mem_req, 1);
        tick();
        mem_ack = 1; #1;
        chk("t4_no_i_ready", i_ready, 0);
        chk("t4_no_d_ready", d_ready, 0);
        tick();
        mem_ack = 0; #1;
        chk("t4_idle_mem_req", mem_req, 0);
        tick();
        chk("t4_d_req", mem_req, 1);
        chk("t4_d_addr", mem_addr, 20'h44440);
        mem_ack = 1; #1;
        chk("t4_d_ready", d_ready, 1);
        tick();
        mem_ack = 0; d_req = 0;
        tick();

        // 5: reset while BUSY_D, then normal service
        d_req = 1; d_addr = 20'h5555A;
        tick();
        chk("t5_busy_req", mem_req, 1);
        rst = 1; mem_ack = 1; d_req = 0; #1;
        chk("t5_rst_d_ready", d_ready, 0);
        tick();
        chk("t5_rst_mem_req", mem_req, 0);
        chk("t5_rst_mem_addr", mem_addr, 0);
        rst = 0; mem_ack = 0;
        tick();
        i_req = 1; i_addr = 20'h6666F;
        tick();
        chk("t5_new_addr", mem_addr, 20'h66660);
        mem_ack = 1; mem_rdata = 128'h7; #1;
        chk("t5_new_i_ready", i_ready, 1);
        tick();
        mem_ack = 0; i_req = 0;
        tick();

        // 6: spurious ack while idle
        mem_ack = 1; #1;
        chk("t6_i_ready", i_ready, 0);
        chk("t6_d_ready", d_ready, 0);
        tick();
        mem_ack = 0; #1;
        chk("t6_mem_req", mem_req, 0);
        tick();
        chk("t6_still_idle", mem_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
